enc_8b10b_tx: RTL and testbench

- Registered 8b/10b encoder: the transmit-side counterpart of the team's 8b/10b decoder chain (6b classification, 5b/6b and 3b/4b mapping, disparity control).
- Accepts one byte plus a control flag per handshake and emits one 10-bit code group.
- Tracks running disparity across symbols.
- Output bit order matches the decoder's data_in, so tx data_out can be looped straight into the rx decoder.

---
 rtl/enc_8b10b_tx.sv | 163 ++++++++++++++++
 tb/tb_enc_8b10b_tx.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/enc_8b10b_tx.sv
// Registered 8b/10b encoder with running-disparity tracking and a one-word output stage.
// Code groups are emitted as {a,b,c,d,e,i,f,g,h,j} with a in bit 9, ready to loop into the rx decoder.
module enc_8b10b_tx #(
    parameter bit RD_INIT = 1'b0,
    parameter bit CHECK_K = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_k,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [9:0] data_out,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       rd_out,
    output logic       k_err
);

    // Sub-block lookup result: the RD- form of the code and whether it is unbalanced.
    typedef struct packed {
        logic       nonzero;
        logic [5:0] code;
    } sub6_t;

    typedef struct packed {
        logic       nonzero;
        logic [3:0] code;
    } sub4_t;

    // RD- column of the 5b/6b table; the RD+ column is the bitwise complement where it differs.
    function automatic sub6_t table6(input logic [4:0] x);
        sub6_t r;
        case (x)
            5'd0:    r = '{1'b1, 6'b100111};
            5'd1:    r = '{1'b1, 6'b011101};
            5'd2:    r = '{1'b1, 6'b101101};
            5'd3:    r = '{1'b0, 6'b110001};
            5'd4:    r = '{1'b1, 6'b110101};
            5'd5:    r = '{1'b0, 6'b101001};
            5'd6:    r = '{1'b0, 6'b011001};
            5'd7:    r = '{1'b0, 6'b111000};
            5'd8:    r = '{1'b1, 6'b111001};
            5'd9:    r = '{1'b0, 6'b100101};
            5'd10:   r = '{1'b0, 6'b010101};
            5'd11:   r = '{1'b0, 6'b110100};
            5'd12:   r = '{1'b0, 6'b001101};
            5'd13:   r = '{1'b0, 6'b101100};
            5'd14:   r = '{1'b0, 6'b011100};
            5'd15:   r = '{1'b1, 6'b010111};
            5'd16:   r = '{1'b1, 6'b011011};
            5'd17:   r = '{1'b0, 6'b100011};
            5'd18:   r = '{1'b0, 6'b010011};
            5'd19:   r = '{1'b0, 6'b110010};
            5'd20:   r = '{1'b0, 6'b001011};
            5'd21:   r = '{1'b0, 6'b101010};
            5'd22:   r = '{1'b0, 6'b011010};
            5'd23:   r = '{1'b1, 6'b111010};
            5'd24:   r = '{1'b1, 6'b110011};
            5'd25:   r = '{1'b0, 6'b100110};
            5'd26:   r = '{1'b0, 6'b010110};
            5'd27:   r = '{1'b1, 6'b110110};
            5'd28:   r = '{1'b0, 6'b001110};
            5'd29:   r = '{1'b1, 6'b101110};
            5'd30:   r = '{1'b1, 6'b011110};
            default: r = '{1'b1, 6'b101011};
        endcase
        return r;
    endfunction

    // RD- column of the 3b/4b data table (primary P7 for y=7).
    function automatic sub4_t table4(input logic [2:0] y);
        sub4_t r;
        case (y)
            3'd0:    r = '{1'b1, 4'b1011};
            3'd1:    r = '{1'b0, 4'b1001};
            3'd2:    r = '{1'b0, 4'b0101};
            3'd3:    r = '{1'b0, 4'b1100};
            3'd4:    r = '{1'b1, 4'b1101};
            3'd5:    r = '{1'b0, 4'b1010};
            3'd6:    r = '{1'b0, 4'b0110};
            default: r = '{1'b1, 4'b1110};
        endcase
        return r;
    endfunction

    logic       rd_cur;
    logic [4:0] x;
    logic [2:0] y;
    logic       k_legal;
    logic       k_use;
    logic       k_bad;
    sub6_t      s6;
    sub4_t      s4;
    logic       flip6;
    logic       flip4;
    logic       rd4;
    logic       alt7;
    logic       rd_next;
    logic [9:0] code;
    logic       accept;

    // NOTE: every signal gets an unconditional assignment before any branch so no latch is inferred.
    always_comb begin
        x       = in_data[4:0];
        y       = in_data[7:5];
        k_legal = (x == 5'd28) ||
                  ((y == 3'd7) && ((x == 5'd23) || (x == 5'd27) || (x == 5'd29) || (x == 5'd30)));
        k_use   = in_k & k_legal;
        k_bad   = in_k & ~k_legal;

        if (k_use && (x == 5'd28)) begin
            s6 = '{1'b1, 6'b001111};
        end else begin
            s6 = table6(x);
        end
        // D.7 is balanced but still alternates with RD.
        flip6 = rd_cur & (s6.nonzero | (x == 5'd7));
        rd4   = rd_cur ^ s6.nonzero;

        alt7 = (y == 3'd7) &&
               (k_use ||
                (~rd4 && ((x == 5'd17) || (x == 5'd18) || (x == 5'd20))) ||
                ( rd4 && ((x == 5'd11) || (x == 5'd13) || (x == 5'd14))));
        if (alt7) begin
            s4 = '{1'b1, 4'b0111};
        end else begin
            s4 = table4(y);
        end

        // K.28 balanced 4b codes use the inverted form when entering at RD-.
        if (k_use && ((y == 3'd1) || (y == 3'd2) || (y == 3'd5) || (y == 3'd6))) begin
            flip4 = ~rd4;
        end else begin
            flip4 = rd4 & (s4.nonzero | (y == 3'd3));
        end

        rd_next = rd4 ^ s4.nonzero;
        code    = {(flip6 ? ~s6.code : s6.code), (flip4 ? ~s4.code : s4.code)};
    end

    assign in_ready = ~out_valid | out_ready;
    assign accept   = in_valid & in_ready;
    assign rd_out   = rd_cur;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            data_out  <= '0;
            k_err     <= 1'b0;
            rd_cur    <= RD_INIT;
        end else if (accept) begin
            out_valid <= 1'b1;
            data_out  <= code;
            k_err     <= CHECK_K & k_bad;
            rd_cur    <= rd_next;
        end else if (out_ready || !out_valid) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_enc_8b10b_tx.sv
// Self-checking bench for enc_8b10b_tx: table-driven reference model, scoreboard queues and a
// monitor that pops one expected word per consumed code group, on two differently parameterised DUTs.
module tb_enc_8b10b_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_data;
    logic       in_k;
    logic       in_valid;
    logic       out_ready;

    logic       in_ready_a, out_valid_a, rd_out_a, k_err_a;
    logic [9:0] data_out_a;
    logic       in_ready_b, out_valid_b, rd_out_b, k_err_b;
    logic [9:0] data_out_b;

    always #5 clk = ~clk;

    enc_8b10b_tx #(.RD_INIT(1'b0), .CHECK_K(1'b1)) dut_a (
        .clk(clk), .reset(reset), .in_data(in_data), .in_k(in_k), .in_valid(in_valid),
        .in_ready(in_ready_a), .data_out(data_out_a), .out_valid(out_valid_a),
        .out_ready(out_ready), .rd_out(rd_out_a), .k_err(k_err_a)
    );

    enc_8b10b_tx #(.RD_INIT(1'b1), .CHECK_K(1'b0)) dut_b (
        .clk(clk), .reset(reset), .in_data(in_data), .in_k(in_k), .in_valid(in_valid),
        .in_ready(in_ready_b), .data_out(data_out_b), .out_valid(out_valid_b),
        .out_ready(out_ready), .rd_out(rd_out_b), .k_err(k_err_b)
    );

    typedef struct packed {
        logic [9:0] code;
        logic       rd;
        logic       kerr;
    } exp_t;

    // Standard code tables, both columns written out, indexed by the RD in force at that sub-block.
    logic [5:0] t6n [32] = '{
        6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
        6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
        6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
        6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
    logic [5:0] t6p [32] = '{
        6'b011000, 6'b100010, 6'b010010, 6'b110001, 6'b001010, 6'b101001, 6'b011001, 6'b000111,
        6'b000110, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b101000,
        6'b100100, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b000101,
        6'b001100, 6'b100110, 6'b010110, 6'b001001, 6'b001110, 6'b010001, 6'b100001, 6'b010100};
    logic [3:0] t4n [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
    logic [3:0] t4p [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b0001};
    // K-symbol 4b column, indexed by the RD at the start of the whole symbol.
    logic [3:0] kn  [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b1000};
    logic [3:0] kp  [8] = '{4'b1011, 4'b0110, 4'b1010, 4'b1100, 4'b1101, 4'b0101, 4'b1001, 4'b0111};

    function automatic exp_t model(input logic [7:0] b, input logic k, input logic rd, input bit check_k);
        exp_t r;
        int   x, y, ones;
        bit   legal, use_k;
        logic [5:0] c6;
        logic [3:0] c4;
        logic rd_mid;
        x     = int'(b[4:0]);
        y     = int'(b[7:5]);
        legal = (x == 28) || (y == 7 && (x == 23 || x == 27 || x == 29 || x == 30));
        use_k = k && legal;
        if (use_k && x == 28) c6 = rd ? 6'b110000 : 6'b001111;
        else                  c6 = rd ? t6p[x] : t6n[x];
        if (use_k) begin
            c4 = rd ? kp[y] : kn[y];
        end else begin
            rd_mid = ($countones(c6) == 3) ? rd : ~rd;
            if (y == 7 && ((!rd_mid && (x == 17 || x == 18 || x == 20)) ||
                           ( rd_mid && (x == 11 || x == 13 || x == 14))))
                c4 = rd_mid ? 4'b1000 : 4'b0111;
            else
                c4 = rd_mid ? t4p[y] : t4n[y];
        end
        r.code = {c6, c4};
        ones   = $countones(r.code);
        r.rd   = (ones == 5) ? rd : (ones > 5);
        r.kerr = k && !legal && check_k;
        return r;
    endfunction

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    exp_t obs_a[$];
    logic rd_a, rd_b;
    bit   rnd_ready = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s: bound expired or unexpected event at cycle %0d", name, cyc);
    endtask

    function automatic logic next_ready();
        return rnd_ready ? logic'($urandom_range(0, 3) != 0) : 1'b1;
    endfunction

    // Monitor: a word is consumed at the posedge following a negedge where out_valid & out_ready.
    initial begin : monitor
        exp_t       e;
        logic [9:0] held_a, held_b;
        logic       hrd_a, hrd_b, stall;
        stall  = 1'b0;
        held_a = '0;
        held_b = '0;
        hrd_a  = 1'b0;
        hrd_b  = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                stall = 1'b0;
                continue;
            end
            if (stall) begin
                check("hold_data_a", 32'(data_out_a), 32'(held_a));
                check("hold_rd_a",   32'(rd_out_a),   32'(hrd_a));
                check("hold_data_b", 32'(data_out_b), 32'(held_b));
                check("hold_rd_b",   32'(rd_out_b),   32'(hrd_b));
            end
            check("in_ready_a", 32'(in_ready_a), 32'(!out_valid_a || out_ready));
            if (out_valid_a && out_ready) begin
                if (q_a.size() == 0) fail_now("extra_word_a");
                else begin
                    e = q_a.pop_front();
                    check("code_a", 32'(data_out_a), 32'(e.code));
                    check("rd_a",   32'(rd_out_a),   32'(e.rd));
                    check("kerr_a", 32'(k_err_a),    32'(e.kerr));
                    obs_a.push_back('{data_out_a, rd_out_a, k_err_a});
                end
            end
            if (out_valid_b && out_ready) begin
                if (q_b.size() == 0) fail_now("extra_word_b");
                else begin
                    e = q_b.pop_front();
                    check("code_b", 32'(data_out_b), 32'(e.code));
                    check("rd_b",   32'(rd_out_b),   32'(e.rd));
                    check("kerr_b", 32'(k_err_b),    32'(e.kerr));
                end
            end
            stall  = out_valid_a && !out_ready;
            held_a = data_out_a;
            hrd_a  = rd_out_a;
            held_b = data_out_b;
            hrd_b  = rd_out_b;
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [7:0] b, input logic k);
        exp_t e;
        int   n;
        n        = 0;
        in_data  = b;
        in_k     = k;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready_a) begin
                e = model(b, k, rd_a, 1'b1);
                q_a.push_back(e);
                rd_a = e.rd;
                e = model(b, k, rd_b, 1'b0);
                q_b.push_back(e);
                rd_b = e.rd;
                break;
            end
            n++;
            if (n > 64) begin
                fail_now("send_timeout");
                break;
            end
            @(posedge clk); #1;
            out_ready = next_ready();
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = next_ready();
    endtask

    task automatic idle();
        in_valid = 1'b0;
        @(posedge clk); #1;
        out_ready = next_ready();
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (q_a.size() == 0 && q_b.size() == 0) break;
            @(posedge clk); #1;
        end
        check("drain_empty", 32'(q_a.size() + q_b.size()), 32'd0);
    endtask

    // Input stays valid while reset is high: it must not be accepted.
    task automatic do_reset();
        reset     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'hB5;
        in_k      = 1'b0;
        out_ready = 1'b0;
        q_a.delete();
        q_b.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid_a", 32'(out_valid_a), 32'd0);
        check("rst_data_a",  32'(data_out_a),  32'd0);
        check("rst_kerr_a",  32'(k_err_a),     32'd0);
        check("rst_rd_a",    32'(rd_out_a),    32'd0);
        check("rst_rd_b",    32'(rd_out_b),    32'd1);
        @(posedge clk); #1;
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        rd_a      = 1'b0;
        rd_b      = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(in_ready_a), 32'd1);
        check("post_rst_valid", 32'(out_valid_a), 32'd0);
        @(posedge clk); #1;
    endtask

    logic [7:0] dir_byte [7] = '{8'hB5, 8'hBC, 8'hBC, 8'h00, 8'hF1, 8'hBC, 8'h21};
    logic       dir_k    [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [9:0] dir_code [7] = '{10'b1010101010, 10'b0011111010, 10'b1100000101, 10'b1001110100,
                                 10'b1000110111, 10'b1100000101, 10'b0111011001};
    logic       dir_rd   [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic       dir_kerr [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [7:0] k_list   [12] = '{8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC,
                                  8'hF7, 8'hFB, 8'hFD, 8'hFE};

    initial begin : stimulus
        int t0;
        in_data   = '0;
        in_k      = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        reset     = 1'b1;
        rd_a      = 1'b0;
        rd_b      = 1'b1;
        @(posedge clk); #1;
        do_reset();

        // Known code groups from RD-, back to back at full rate.
        obs_a.delete();
        t0 = cyc;
        for (int i = 0; i < 7; i++) send(dir_byte[i], dir_k[i]);
        check("throughput_cycles", 32'(cyc - t0), 32'd7);
        drain();
        check("dir_count", 32'(obs_a.size()), 32'd7);
        for (int i = 0; i < 7 && i < obs_a.size(); i++) begin
            check("dir_code", 32'(obs_a[i].code), 32'(dir_code[i]));
            check("dir_rd",   32'(obs_a[i].rd),   32'(dir_rd[i]));
            check("dir_kerr", 32'(obs_a[i].kerr), 32'(dir_kerr[i]));
        end
        @(negedge clk);
        check("idle_valid", 32'(out_valid_a), 32'd0);
        if (obs_a.size() > 0) check("idle_data_hold", 32'(data_out_a), 32'(obs_a[obs_a.size()-1].code));
        @(posedge clk); #1;

        // Backpressure: a second word waits while the first is held.
        send(8'h4A, 1'b0);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h9C;
        in_k      = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stall_in_ready", 32'(in_ready_a), 32'd0);
            check("stall_valid",    32'(out_valid_a), 32'd1);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        send(8'h9C, 1'b0);
        drain();

        // All data bytes twice and all legal K codes, with random backpressure and gaps.
        rnd_ready = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            for (int b = 0; b < 256; b++) begin
                send(8'(b), 1'b0);
                if ($urandom_range(0, 7) == 0) idle();
            end
            for (int i = 0; i < 12; i++) begin
                send(k_list[i], 1'b1);
                send(k_list[$urandom_range(0, 11)], 1'b1);
            end
        end
        for (int i = 0; i < 300; i++) begin
            send(8'($urandom_range(0, 255)), logic'($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 5) == 0) idle();
        end
        rnd_ready = 1'b0;
        drain();

        // Reset while a word with RD+ is held on the output.
        do_reset();
        send(8'hBC, 1'b1);
        out_ready = 1'b0;
        @(negedge clk);
        check("pre_rst_valid", 32'(out_valid_a), 32'd1);
        check("pre_rst_rd",    32'(rd_out_a),    32'd1);
        @(posedge clk); #1;
        do_reset();
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
